// File: rtl/irq_ctrl_if.sv
// Single-word slave register bus: request on cs/as, response one cycle later
// on rdy/rd_data.
interface irq_ctrl_if;
  logic        cs;
  logic        as;
  logic        rw;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy;

  modport master (output cs, as, rw, addr, wr_data, input rd_data, rdy);
  modport slave  (input cs, as, rw, addr, wr_data, output rd_data, rdy);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line sync/latch/mask lanes plus a register block
// for status, mask, mode, clear and priority readout.

module irq_ctrl_lane (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic mask,
  input  logic clr,
  output logic pend,
  output logic line
);
  logic meta, sync, prev, set;

  // prev keeps tracking in both modes so a level->edge switch sees no false edge
  assign set = edge_mode ? (sync & ~prev) : sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      pend <= 1'b0;
      line <= 1'b0;
    end else begin
      meta <= irq;
      sync <= meta;
      prev <= sync;
      pend <= set | (pend & ~clr);
      line <= pend & mask;
    end
  end
endmodule

module irq_ctrl #(
  parameter int                 IRQ_N      = 6,
  parameter logic [IRQ_N-1:0]   RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  irq_ctrl_if.slave        bus,
  input  logic [IRQ_N-1:0] irq_i,
  output logic [IRQ_N-1:0] int_o
);
  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_MODE    = 3'd2;
  localparam logic [2:0] A_CLEAR   = 3'd3;
  localparam logic [2:0] A_ACTIVE  = 3'd4;
  localparam logic [2:0] A_HIGHEST = 3'd5;

  typedef struct packed {
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] data;
  } req_t;

  req_t             req;
  logic             acc, wr_en;
  logic [IRQ_N-1:0] mask_q, mode_q, pending, active, clr;
  logic [3:0]       hi_idx;
  logic [31:0]      rd_val;
  logic             rdy_q;
  logic [31:0]      rd_q;

  assign req   = '{rw: bus.rw, addr: bus.addr, data: bus.wr_data};
  assign acc   = bus.cs & bus.as;
  assign wr_en = acc & ~req.rw;
  assign clr   = (wr_en && req.addr == A_CLEAR) ? req.data[IRQ_N-1:0] : '0;

  irq_ctrl_lane u_lane [IRQ_N-1:0] (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq_i),
    .edge_mode(mode_q),
    .mask     (mask_q),
    .clr      (clr),
    .pend     (pending),
    .line     (int_o)
  );

  assign active = pending & mask_q;

  // Scan downward so the lowest active index wins
  always_comb begin
    hi_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--)
      if (active[i]) hi_idx = 4'(i);
  end

  always_comb begin
    rd_val = '0;
    case (req.addr)
      A_STATUS:  rd_val = 32'(pending);
      A_MASK:    rd_val = 32'(mask_q);
      A_MODE:    rd_val = 32'(mode_q);
      A_ACTIVE:  rd_val = 32'(active);
      A_HIGHEST: rd_val = {|active, 27'd0, hi_idx};
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= RESET_MASK;
      mode_q <= '0;
      rdy_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (wr_en && req.addr == A_MASK) mask_q <= req.data[IRQ_N-1:0];
      if (wr_en && req.addr == A_MODE) mode_q <= req.data[IRQ_N-1:0];
      rdy_q <= acc;
      rd_q  <= (acc && req.rw) ? rd_val : '0;
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.rd_data = rd_q;
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Bus-slave interrupt controller between the peripheral interrupt sources (timer, UART, GPIO and spares) and the 6-bit CPU interrupt input of the core.
- Synchronises raw sources, latches them as edge- or level-triggered pending bits, and masks them. Drives registered per-line CPU interrupt outputs.
- Exposes status, mask, mode, clear and priority registers through the standard single-word slave handshake (cs/as/rw/addr/wr_data/rd_data/rdy).

Parameters:
- IRQ_N, 6, number of interrupt sources and CPU interrupt lines (1..16).
- RESET_MASK, 0, reset value of the MASK register (IRQ_N bits); 1 = enabled.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  slave chip select from the address decoder.
- as  in  1  address strobe; access starts when cs & as.
- rw  in  1  1 = read, 0 = write.
- addr  in  3  word register index.
- wr_data  in  32  write data.
- rd_data  out  32  read data; valid only while rdy = 1, else 0.
- rdy  out  1  one-cycle access-complete pulse.
- irq_i  in  IRQ_N  raw interrupt sources, asynchronous to clk.
- int_o  out  IRQ_N  registered interrupt lines to the CPU int_i.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Synchronisers, previous-value flops, PENDING and MODE clear to 0.
  - MASK loads RESET_MASK.
  - rd_data, rdy and int_o are 0.
- Input path:
  - Two-flop synchroniser per bit gives sync[i]; a third flop gives prev[i].
  - Edge mode (MODE[i] = 1): set event = sync[i] & ~prev[i] (rising edge).
  - Level mode (MODE[i] = 0): set event = sync[i].
- PENDING update, each cycle: PENDING[i] <= set[i] | (PENDING[i] & ~clr[i]).
  - clr[i] is a write of 1 to CLEAR bit i in this cycle.
  - Set and clear in the same cycle: set wins, so the bit stays pending.
  - A level source still high re-sets its bit on the next cycle; clearing it is ineffective.
- int_o[i] <= PENDING[i] & MASK[i], registered.
  - Latency from an irq_i rising edge to int_o = 4 clk: 2 sync + 1 pending + 1 output.
  - Masking or clearing removes int_o one clk after PENDING/MASK change.
- Register map (addr):
  - 0 STATUS, RO: PENDING, zero-extended.
  - 1 MASK, RW: low IRQ_N bits.
  - 2 MODE, RW: 1 = rising edge, 0 = level.
  - 3 CLEAR, WO: write 1 to clear bit; reads return 0.
  - 4 ACTIVE, RO: PENDING & MASK.
  - 5 HIGHEST, RO: bit31 = any ACTIVE bit; bits[3:0] = lowest-index active line (index 0 has highest priority); 0 when none.
  - 6, 7 reserved: reads return 0, writes are ignored.
  - Writes ignore bits above IRQ_N-1.
- Handshake:
  - An access is accepted in the cycle cs & as = 1.
  - Writes take effect at that clock edge.
  - rdy = 1 and rd_data = register value in the next cycle, sampled at the accept edge.
  - rdy is a single pulse. A back-to-back access (cs & as held) is accepted every cycle, so rdy stays high and each cycle returns the data for the previous cycle's access.
  - as without cs: no effect.
  - Read of MASK/MODE in the cycle after a write returns the new value.
- Changing MODE from level to edge: PENDING is kept, and prev continues tracking, so no spurious edge is generated.
- Reset mid-access: rdy drops immediately and the access is lost; the master must retry.

Test Plan:
- After reset release, read every register → STATUS 0, MASK RESET_MASK, MODE 0, ACTIVE 0, HIGHEST 0x00000000. int_o = 0; rdy pulses exactly one cycle per access.
- MODE = 0x3F, MASK = 0x3F, pulse irq_i[2] high for 1 clk:
  - int_o = 6'b000100 exactly 4 clk later; STATUS = 0x4; HIGHEST = 0x80000002.
  - Write CLEAR = 0x4 → int_o = 0 one clk after PENDING clears.
- Level mode (MODE = 0), irq_i[0] held high:
  - Write CLEAR = 0x1 → STATUS still 0x1.
  - Drop irq_i[0], wait 3 clk, CLEAR = 0x1 → STATUS 0.
- Edge mode, rising edge on irq_i[1] lands in the same cycle as CLEAR = 0x2 → STATUS bit 1 remains 1.
- MASK = 0, edges on irq_i[5] and irq_i[3]:
  - STATUS = 0x28, ACTIVE = 0, int_o = 0.
  - MASK = 0x20 → int_o = 6'b100000 after 1 clk; HIGHEST = 0x80000005.
- Assert rst low mid-read with irq pending → rdy, rd_data and int_o go to 0 asynchronously; STATUS reads 0 after release.
